// File: rtl/spi_frame_rx_if.sv
// Output bus of the SPI frame receiver: received header/message fields with a
// valid/ready handshake toward the downstream consumer.
interface spi_frame_rx_if #(
  parameter int unsigned MESSAGE_SIZE = 512,
  parameter int unsigned HEADER_SIZE  = 32
) ();
  logic [MESSAGE_SIZE-1:0] message_out;
  logic [HEADER_SIZE-1:0]  header_out;
  logic                    valid_out;
  logic                    ready_in;

  modport master (
    output message_out,
    output header_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  message_out,
    input  header_out,
    input  valid_out,
    output ready_in
  );
endinterface

// File: rtl/spi_frame_rx.sv
// Peripheral-side SPI frame receiver: synchronises the pins, deserialises one
// {message, header} frame into a one-entry buffer. Option: SPI_RX_SHORT_FRAME_ERR_EN.
module spi_frame_rx #(
  parameter int unsigned MESSAGE_SIZE = 512,
  parameter int unsigned HEADER_SIZE  = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           data_in,
  input  logic           data_clk_in,
  input  logic           sel_in,
  spi_frame_rx_if.master out_if,
  output logic           overrun_out,
  output logic           err_out
);
  localparam int unsigned FRAME = MESSAGE_SIZE + HEADER_SIZE;
  localparam int unsigned CNT_W = $clog2(FRAME + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DRAIN} state_e;

  // Pin synchronisers; sel_vld_q marks when the sel chain holds real pin samples
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] sel_sync_q;
  logic [SYNC_STAGES-1:0] sel_vld_q;
  logic                   clk_prev_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_sync_q <= '0;
      clk_sync_q  <= '0;
      sel_sync_q  <= '1;
      sel_vld_q   <= '0;
      clk_prev_q  <= 1'b0;
    end else begin
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_in};
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], data_clk_in};
      sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], sel_in};
      sel_vld_q   <= {sel_vld_q[SYNC_STAGES-2:0], 1'b1};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  logic data_s_c;
  logic sel_s_c;
  logic sel_real_c;
  logic edge_c;

  assign data_s_c   = data_sync_q[SYNC_STAGES-1];
  assign sel_s_c    = sel_sync_q[SYNC_STAGES-1];
  assign sel_real_c = sel_vld_q[SYNC_STAGES-1];
  assign edge_c     = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME-1:0]        shreg_q, shreg_d;
  logic                    armed_q, armed_d;
  logic [MESSAGE_SIZE-1:0] msg_q, msg_d;
  logic [HEADER_SIZE-1:0]  hdr_q, hdr_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
`ifdef SPI_RX_SHORT_FRAME_ERR_EN
  logic                    err_q, err_d;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      armed_q   <= 1'b0;
      msg_q     <= '0;
      hdr_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SPI_RX_SHORT_FRAME_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      armed_q   <= armed_d;
      msg_q     <= msg_d;
      hdr_q     <= hdr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef SPI_RX_SHORT_FRAME_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  // A frame only starts after sel has been seen high in IDLE (armed), so a
  // reset in the middle of a frame never resumes on the tail of that frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    armed_d   = armed_q;
    msg_d     = msg_q;
    hdr_d     = hdr_q;
    valid_d   = valid_q & ~out_if.ready_in;
    overrun_d = 1'b0;
`ifdef SPI_RX_SHORT_FRAME_ERR_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sel_real_c && sel_s_c) begin
          armed_d = 1'b1;
        end
        if (armed_q && !sel_s_c) begin
          state_d = SHIFT;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
      SHIFT: begin
        if (sel_s_c) begin
          state_d = IDLE;
`ifdef SPI_RX_SHORT_FRAME_ERR_EN
          err_d   = 1'b1;
`endif
        end else if (edge_c) begin
          shreg_d = {shreg_q[FRAME-2:0], data_s_c};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME - 1)) begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        state_d = DRAIN;
        if (!valid_q || out_if.ready_in) begin
          msg_d   = shreg_q[FRAME-1:HEADER_SIZE];
          hdr_d   = shreg_q[HEADER_SIZE-1:0];
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      DRAIN: begin
        if (sel_s_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_if.message_out = msg_q;
  assign out_if.header_out  = hdr_q;
  assign out_if.valid_out   = valid_q;
  assign overrun_out        = overrun_q;
`ifdef SPI_RX_SHORT_FRAME_ERR_EN
  assign err_out            = err_q;
`else
  assign err_out            = 1'b0;
`endif
endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomised frame bench for spi_frame_rx: a one-entry-buffer reference model
// pushes expected frames, an independent monitor pops them on each handshake.
module tb_spi_frame_rx;
  localparam int unsigned MSG   = 512;
  localparam int unsigned HDR   = 32;
  localparam int unsigned FRAME = MSG + HDR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data = 1'b0;
  logic dclk = 1'b0;
  logic sel = 1'b1;
  logic overrun;
  logic err;

  spi_frame_rx_if #(.MESSAGE_SIZE(MSG), .HEADER_SIZE(HDR)) bus ();

  spi_frame_rx #(.MESSAGE_SIZE(MSG), .HEADER_SIZE(HDR), .SYNC_STAGES(2)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .data_in     (data),
    .data_clk_in (dclk),
    .sel_in      (sel),
    .out_if      (bus),
    .overrun_out (overrun),
    .err_out     (err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int ovr_seen   = 0;
  int err_seen   = 0;
  int ph_lo      = 3;
  int ph_hi      = 3;
  logic [FRAME-1:0] exp_q[$];

`ifdef SPI_RX_SHORT_FRAME_ERR_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  task automatic chk_f(input string name, input logic [FRAME-1:0] got, input logic [FRAME-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [FRAME-1:0] rand_frame();
    logic [FRAME-1:0] f;
    for (int j = 0; j < int'(FRAME / 32); j++) f[j*32 +: 32] = $urandom;
    return f;
  endfunction

  function automatic logic [FRAME-1:0] cur_frame();
    return {bus.message_out, bus.header_out};
  endfunction

  // Sends v[n-1] .. v[0] MSB first. mode 1: measure cycles from the last rising
  // edge to valid; mode 2: pulse ready on the cycle the frame gets loaded.
  task automatic send_bits(input logic [559:0] v, input int n, input bit raise_sel,
                           input int mode, output int lat);
    lat = 0;
    sel = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      data = v[i];
      dclk = 1'b0;
      tick($urandom_range(ph_hi, ph_lo));
      dclk = 1'b1;
      if (i == 0 && mode != 0) begin
        for (int k = 1; k <= 8; k++) begin
          tick(1);
          if (mode == 1 && bus.valid_out && lat == 0) lat = k;
          if (mode == 2 && k == 3) bus.ready_in = 1'b1;
          if (mode == 2 && k == 4) bus.ready_in = 1'b0;
        end
      end else begin
        tick($urandom_range(ph_hi, ph_lo));
      end
    end
    dclk = 1'b0;
    tick(ph_lo);
    if (raise_sel) begin
      sel = 1'b1;
      tick(6);
    end
  endtask

  // Monitor: every handshake must match the oldest expected frame
  initial begin
    logic [FRAME-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.valid_out && bus.ready_in) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_frame: got %h expected none", cur_frame());
          end else begin
            e = exp_q.pop_front();
            chk_f("handshake_frame", cur_frame(), e);
          end
        end
        if (overrun) ovr_seen++;
        if (err) err_seen++;
      end
    end
  end

  initial begin
    logic [FRAME-1:0] f1, f2, f3, f4, f, g;
    logic [15:0] extra;
    int lat;
    bus.ready_in = 1'b0;
    tick(3);
    chk_i("reset_valid", int'(bus.valid_out), 0);
    chk_f("reset_frame", cur_frame(), '0);
    chk_i("reset_overrun", int'(overrun), 0);
    chk_i("reset_err", int'(err), 0);
    rst = 1'b0;
    tick(5);

    // Known frame, buffer held (ready low), latency from last edge
    f1 = {{8{64'h0123_4567_89AB_CDEF}}, 32'hA5A5_0001};
    exp_q.push_back(f1);
    send_bits(560'(f1), FRAME, 1'b1, 1, lat);
    chk_i("latency", lat, 4);
    chk_f("header", {{MSG{1'b0}}, bus.header_out}, {{MSG{1'b0}}, 32'hA5A5_0001});
    chk_f("message", {bus.message_out, {HDR{1'b0}}}, {{8{64'h0123_4567_89AB_CDEF}}, {HDR{1'b0}}});

    // Second frame into a full buffer is dropped with one overrun pulse
    f2 = rand_frame();
    send_bits(560'(f2), FRAME, 1'b1, 0, lat);
    chk_i("ovr_valid_held", int'(bus.valid_out), 1);
    chk_f("ovr_frame_held", cur_frame(), f1);
    chk_i("ovr_pulses", ovr_seen, 1);
    bus.ready_in = 1'b1;
    tick(1);
    bus.ready_in = 1'b0;
    tick(1);
    chk_i("consumed_valid", int'(bus.valid_out), 0);

    // Consume on the exact load cycle: new frame replaces the old, no overrun
    f3 = rand_frame();
    exp_q.push_back(f3);
    send_bits(560'(f3), FRAME, 1'b1, 0, lat);
    f4 = rand_frame();
    exp_q.push_back(f4);
    send_bits(560'(f4), FRAME, 1'b1, 2, lat);
    chk_i("same_cycle_valid", int'(bus.valid_out), 1);
    chk_f("same_cycle_frame", cur_frame(), f4);
    chk_i("same_cycle_no_ovr", ovr_seen, 1);
    bus.ready_in = 1'b1;
    tick(2);

    // Short frame of 100 bits, then a full frame
    g = rand_frame();
    send_bits(560'(g >> (FRAME - 100)), 100, 1'b1, 0, lat);
    tick(4);
    chk_i("short_err", err_seen, EXP_ERR);
    chk_i("short_no_valid", int'(bus.valid_out), 0);
    f = rand_frame();
    exp_q.push_back(f);
    send_bits(560'(f), FRAME, 1'b1, 0, lat);
    tick(4);
    chk_i("after_short_drained", exp_q.size(), 0);

    // Reset mid-frame with a held frame in the buffer
    bus.ready_in = 1'b0;
    f = rand_frame();
    send_bits(560'(f), FRAME, 1'b1, 0, lat);
    chk_i("held_before_reset", int'(bus.valid_out), 1);
    g = rand_frame();
    send_bits(560'(g >> (FRAME - 200)), 200, 1'b0, 0, lat);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_i("mid_reset_valid", int'(bus.valid_out), 0);
    chk_f("mid_reset_frame", cur_frame(), '0);
    tick(20);
    sel = 1'b1;
    tick(6);
    bus.ready_in = 1'b1;
    f = rand_frame();
    exp_q.push_back(f);
    send_bits(560'(f), FRAME, 1'b1, 0, lat);

    // 560 edges in one select window: only the first 544 bits count
    f = rand_frame();
    extra = 16'($urandom);
    exp_q.push_back(f);
    send_bits({f, extra}, 560, 1'b1, 0, lat);

    // Random frames with random pin phase lengths
    ph_hi = 5;
    for (int r = 0; r < 5; r++) begin
      f = rand_frame();
      exp_q.push_back(f);
      send_bits(560'(f), FRAME, 1'b1, 0, lat);
    end
    tick(20);
    chk_i("queue_empty", exp_q.size(), 0);
    chk_i("total_overruns", ovr_seen, 1);
    chk_i("total_errs", err_seen, EXP_ERR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
